// File: rtl/fp_pkg.sv
// Shared constants, raw-fraction field layout and FSM state type for the FP adder back end.
package fp_pkg;

    localparam int unsigned EXP_W  = 8;
    localparam int unsigned MAN_W  = 23;
    localparam int unsigned GRS_W  = 3;
    localparam int unsigned FRAC_W = MAN_W + 2 + GRS_W;
    localparam int unsigned BIAS   = 127;

    // Exponent arithmetic is one bit wider than the field so overflow never wraps.
    localparam logic [EXP_W:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};
    localparam logic [EXP_W:0] EXP_ONE = {{EXP_W{1'b0}}, 1'b1};

    // Raw fraction layout: carry, hidden, mantissa, guard, round, sticky.
    localparam int unsigned CARRY_BIT  = FRAC_W - 1;
    localparam int unsigned HIDDEN_BIT = FRAC_W - 2;
    localparam int unsigned MAN_MSB    = FRAC_W - 3;
    localparam int unsigned MAN_LSB    = GRS_W;
    localparam int unsigned G_BIT      = 2;
    localparam int unsigned R_BIT      = 1;
    localparam int unsigned S_BIT      = 0;

    typedef enum logic [1:0] {
        StIdle,
        StNorm,
        StRound,
        StDone
    } fp_state_e;

endpackage

// File: rtl/fp_normalize_pack_if.sv
// Raw-sum input and packed-result output handshakes of the normalise/pack stage.
interface fp_normalize_pack_if;
    import fp_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic                in_sign;
    logic [EXP_W-1:0]    in_exp;
    logic [FRAC_W-1:0]   in_frac;
    logic                out_valid;
    logic                out_ready;
    logic [31:0]         out_result;
    logic                out_overflow;
    logic                out_underflow;

    // Producer of raw sums and consumer of results.
    modport master (
        output in_valid, in_sign, in_exp, in_frac, out_ready,
        input  in_ready, out_valid, out_result, out_overflow, out_underflow
    );

    // The normalise/pack block itself.
    modport slave (
        input  in_valid, in_sign, in_exp, in_frac, out_ready,
        output in_ready, out_valid, out_result, out_overflow, out_underflow
    );

endinterface

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even increment of the stored mantissa from its G/R/S bits.
module fp_round_rne
    import fp_pkg::*;
(
    input  logic [MAN_W-1:0] mant,
    input  logic             g,
    input  logic             r,
    input  logic             s,
    output logic [MAN_W-1:0] mant_rnd,
    output logic             carry
);

    logic           inc;
    logic [MAN_W:0] sum;

    // Round up above half, or exactly half when the LSB is odd.
    always_comb begin
        inc = g & (r | s | mant[0]);
        sum = {1'b0, mant} + {{MAN_W{1'b0}}, inc};
        mant_rnd = sum[MAN_W-1:0];
        carry = sum[MAN_W];
    end

endmodule

// File: rtl/fp_normalize_pack.sv
// Normalise, RNE-round and pack a raw signed sum into binary32.
// Optional flush-to-zero of denormal results when FP_NORM_FTZ_EN is defined.
module fp_normalize_pack
    import fp_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    fp_normalize_pack_if.slave  bus
);

    fp_state_e           state_q, state_d;
    logic                sign_q, sign_d;
    logic [EXP_W:0]      exp_q, exp_d;
    logic [FRAC_W-2:0]   frac_q, frac_d;   // carry bit is consumed on accept
    logic [31:0]         result_q, result_d;
    logic                ovf_q, ovf_d;
    logic                udf_q, udf_d;

    logic [MAN_W-1:0]    mant_rnd;
    logic                rnd_carry;
    logic [EXP_W:0]      exp_field;
    logic [EXP_W:0]      exp_rnd;
    logic [GRS_W-1:0]    grs;

    fp_round_rne u_round (
        .mant     (frac_q[MAN_MSB:MAN_LSB]),
        .g        (frac_q[G_BIT]),
        .r        (frac_q[R_BIT]),
        .s        (frac_q[S_BIT]),
        .mant_rnd (mant_rnd),
        .carry    (rnd_carry)
    );

    // Denormals encode exponent 0; a rounding carry bumps the field (denormal -> 1).
    always_comb begin
        grs = frac_q[G_BIT:S_BIT];
        exp_field = frac_q[HIDDEN_BIT] ? exp_q : '0;
        exp_rnd = rnd_carry ? exp_field + EXP_ONE : exp_field;
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        frac_d   = frac_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    sign_d = bus.in_sign;
                    ovf_d  = 1'b0;
                    udf_d  = 1'b0;
                    if (bus.in_exp == EXP_MAX[EXP_W-1:0]) begin
                        result_d = {bus.in_sign, bus.in_exp, bus.in_frac[MAN_MSB:MAN_LSB]};
                        state_d  = StDone;
                    end else if (bus.in_frac == '0) begin
                        result_d = {bus.in_sign, {(EXP_W + MAN_W){1'b0}}};
                        state_d  = StDone;
                    end else if (bus.in_frac[CARRY_BIT]) begin
                        // Shift right once; the bit falling off is folded into sticky.
                        frac_d  = {bus.in_frac[CARRY_BIT:2], bus.in_frac[1] | bus.in_frac[0]};
                        exp_d   = {1'b0, bus.in_exp} + EXP_ONE;
                        state_d = StNorm;
                    end else begin
                        frac_d  = bus.in_frac[HIDDEN_BIT:0];
                        exp_d   = {1'b0, bus.in_exp};
                        state_d = StNorm;
                    end
                end
            end
            StNorm: begin
                if (!frac_q[HIDDEN_BIT] && (exp_q > EXP_ONE)) begin
                    // Sticky stays set once set: it stands for nonzero bits far below.
                    frac_d = {frac_q[HIDDEN_BIT-1:0], 1'b0} |
                             {{(FRAC_W-2){1'b0}}, frac_q[S_BIT]};
                    exp_d  = exp_q - EXP_ONE;
                end else begin
                    state_d = StRound;
                end
            end
            StRound: begin
                if (exp_rnd >= EXP_MAX) begin
                    result_d = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    ovf_d    = 1'b1;
                end else begin
                    result_d = {sign_q, exp_rnd[EXP_W-1:0], mant_rnd};
`ifdef FP_NORM_FTZ_EN
                    if ((exp_rnd == '0) && (mant_rnd != '0)) begin
                        result_d = {sign_q, {(EXP_W + MAN_W){1'b0}}};
                        udf_d    = 1'b1;
                    end
`else
                    udf_d = (exp_rnd == '0) && (grs != '0);
`endif
                end
                state_d = StDone;
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset drops any in-flight value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            frac_q   <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            frac_q   <= frac_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Handshake outputs; in_ready is held low while reset is asserted.
    always_comb begin
        bus.in_ready      = rst_n && (state_q == StIdle);
        bus.out_valid     = (state_q == StDone);
        bus.out_result    = result_q;
        bus.out_overflow  = ovf_q;
        bus.out_underflow = udf_q;
    end

endmodule

// File: tb/tb_fp_normalize_pack.sv
// Directed and randomised checks of fp_normalize_pack against a numeric reference model.
module tb_fp_normalize_pack;
    import fp_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    fp_normalize_pack_if bus ();

    fp_normalize_pack dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference: treat the raw fraction as a significand with 3 extra bits, normalise by
    // value, round half-to-even on the integer significand, then encode.
    function automatic void model(input logic sgn, input logic [7:0] e_in,
                                  input logic [27:0] f_in, output logic [31:0] res,
                                  output logic ovf, output logic udf, output int lat);
        int          e;
        int          k;
        int          sig;
        int          field;
        logic [27:0] f;
        logic [2:0]  grs;
        logic [22:0] mant;
        logic [7:0]  fe;
        logic        up;
        ovf = 1'b0;
        udf = 1'b0;
        lat = 0;
        if (e_in == 8'd255) begin
            res = {sgn, 8'hFF, f_in[25:3]};
            return;
        end
        if (f_in == 28'd0) begin
            res = {sgn, 31'd0};
            return;
        end
        e = int'(e_in);
        f = f_in;
        if (f[27]) begin
            f = (f >> 1) | {27'd0, f_in[0]};
            e = e + 1;
        end
        k = 0;
        while (f[26] == 1'b0 && e > 1) begin
            f = (f << 1) | (f & 28'h1);
            e = e - 1;
            k = k + 1;
        end
        lat = k + 2;
        grs = f[2:0];
        sig = int'(f[26:3]);
        up = grs[2] && (grs[1] || grs[0] || (sig % 2 == 1));
        sig = sig + (up ? 1 : 0);
        if (f[26]) begin
            field = e;
            if (sig == (1 << 24)) begin
                sig = 1 << 23;
                field = field + 1;
            end
        end else begin
            field = (sig == (1 << 23)) ? 1 : 0;
        end
        if (field >= 255) begin
            res = {sgn, 8'hFF, 23'd0};
            ovf = 1'b1;
            return;
        end
        mant = sig[22:0];
        fe = field[7:0];
        res = {sgn, fe, mant};
`ifdef FP_NORM_FTZ_EN
        if (field == 0 && mant != 23'd0) begin
            res = {sgn, 31'd0};
            udf = 1'b1;
        end
`else
        udf = (field == 0) && (grs != 3'd0);
`endif
    endfunction

    // One transaction with explicit expectations; stall holds out_ready low after valid.
    task automatic run_dir(input string tag, input logic sgn, input logic [7:0] e,
                           input logic [27:0] f, input logic [31:0] xr, input logic xo,
                           input logic xu, input int xl, input int stall);
        int lat;
        bus.out_ready = (stall == 0);
        total++;
        assert (bus.in_ready === 1'b1) else begin
            bad++;
            $error("FAIL %s in_ready idle: got %b want 1", tag, bus.in_ready);
        end
        bus.in_valid = 1'b1;
        bus.in_sign = sgn;
        bus.in_exp = e;
        bus.in_frac = f;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        total++;
        assert (lat === xl) else begin
            bad++;
            $error("FAIL %s latency: got %0d want %0d", tag, lat, xl);
        end
        total++;
        assert (bus.out_result === xr) else begin
            bad++;
            $error("FAIL %s result: got %h want %h", tag, bus.out_result, xr);
        end
        total++;
        assert (bus.out_overflow === xo) else begin
            bad++;
            $error("FAIL %s overflow: got %b want %b", tag, bus.out_overflow, xo);
        end
        total++;
        assert (bus.out_underflow === xu) else begin
            bad++;
            $error("FAIL %s underflow: got %b want %b", tag, bus.out_underflow, xu);
        end
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            total++;
            assert (bus.out_valid === 1'b1 && bus.out_result === xr && bus.in_ready === 1'b0)
            else begin
                bad++;
                $error("FAIL %s stall%0d: got v=%b r=%h rdy=%b want v=1 r=%h rdy=0", tag, i,
                       bus.out_valid, bus.out_result, bus.in_ready, xr);
            end
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        total++;
        assert (bus.out_valid === 1'b0) else begin
            bad++;
            $error("FAIL %s valid drop: got %b want 0", tag, bus.out_valid);
        end
    endtask

    task automatic run_model(input string tag, input logic sgn, input logic [7:0] e,
                             input logic [27:0] f);
        logic [31:0] xr;
        logic        xo;
        logic        xu;
        int          xl;
        model(sgn, e, f, xr, xo, xu, xl);
        run_dir(tag, sgn, e, f, xr, xo, xu, xl, 0);
    endtask

    initial begin
        logic [31:0] r32;
        logic [27:0] f;
        logic [7:0]  e;
        int          seen;
        bus.in_valid = 1'b0;
        bus.in_sign = 1'b0;
        bus.in_exp = '0;
        bus.in_frac = '0;
        bus.out_ready = 1'b1;

        #12;
        total++;
        assert (bus.in_ready === 1'b0 && bus.out_valid === 1'b0 && bus.out_result === 32'd0 &&
                bus.out_overflow === 1'b0 && bus.out_underflow === 1'b0) else begin
            bad++;
            $error("FAIL reset outputs: got rdy=%b v=%b r=%h o=%b u=%b want all 0",
                   bus.in_ready, bus.out_valid, bus.out_result, bus.out_overflow,
                   bus.out_underflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_dir("carry", 1'b0, 8'd127, 28'h8000000, 32'h40000000, 1'b0, 1'b0, 2, 0);
        run_dir("lshift2", 1'b0, 8'd130, 28'h1000000, 32'h40000000, 1'b0, 1'b0, 4, 0);
        run_dir("tie_up", 1'b0, 8'd127, 28'h400000C, 32'h3F800002, 1'b0, 1'b0, 2, 0);
        run_dir("tie_even", 1'b0, 8'd127, 28'h4000004, 32'h3F800000, 1'b0, 1'b0, 2, 0);
        run_dir("overflow", 1'b0, 8'd254, 28'h8000000, 32'h7F800000, 1'b1, 1'b0, 2, 0);
        run_dir("neg_zero", 1'b1, 8'd100, 28'h0000000, 32'h80000000, 1'b0, 1'b0, 0, 0);
        run_dir("inf_nan", 1'b0, 8'd255, 28'h4000008, 32'h7F800001, 1'b0, 1'b0, 0, 0);
`ifdef FP_NORM_FTZ_EN
        run_dir("denorm", 1'b0, 8'd1, 28'h0000008, 32'h00000000, 1'b0, 1'b1, 2, 0);
`else
        run_dir("denorm", 1'b0, 8'd1, 28'h0000008, 32'h00000001, 1'b0, 1'b0, 2, 0);
`endif
        run_dir("mant_carry", 1'b1, 8'd127, 28'h7FFFFFC, 32'hC0000000, 1'b0, 1'b0, 2, 0);
        run_dir("backpress", 1'b0, 8'd127, 28'h4000000, 32'h3F800000, 1'b0, 1'b0, 2, 5);

        // Randomised operands biased toward the denormal and overflow edges.
        for (int n = 0; n < 60; n++) begin
            r32 = $urandom();
            f = r32[27:0] >> $urandom_range(0, 27);
            case ($urandom_range(0, 3))
                0: e = 8'($urandom_range(1, 6));
                1: e = 8'($urandom_range(250, 254));
                default: e = 8'($urandom_range(1, 254));
            endcase
            run_model($sformatf("rand%0d", n), r32[31], e, f);
        end

        // Reset while normalising: outputs clear and the value never appears.
        bus.in_valid = 1'b1;
        bus.in_sign = 1'b0;
        bus.in_exp = 8'd200;
        bus.in_frac = 28'h0000100;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        assert (bus.in_ready === 1'b0 && bus.out_valid === 1'b0 && bus.out_result === 32'd0 &&
                bus.out_overflow === 1'b0 && bus.out_underflow === 1'b0) else begin
            bad++;
            $error("FAIL midreset outputs: got rdy=%b v=%b r=%h o=%b u=%b want all 0",
                   bus.in_ready, bus.out_valid, bus.out_result, bus.out_overflow,
                   bus.out_underflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        assert (bus.in_ready === 1'b1) else begin
            bad++;
            $error("FAIL midreset idle ready: got %b want 1", bus.in_ready);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid === 1'b1) seen++;
        end
        total++;
        assert (seen === 0) else begin
            bad++;
            $error("FAIL midreset no result: got %0d valid cycles want 0", seen);
        end

        run_dir("after_reset", 1'b1, 8'd128, 28'h4000000, 32'hC0000000, 1'b0, 1'b0, 2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
